fifo_prefill_reader: RTL and testbench



---
 rtl/fifo_prefill_reader_pkg.sv | 18 +
 rtl/fifo_prefill_reader_skid.sv | 78 +++++++
 rtl/fifo_prefill_reader.sv | 126 ++++++++++++
 tb/tb_fifo_prefill_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_prefill_reader_pkg.sv
// rtl/fifo_prefill_reader_pkg.sv - shared state encodings and width helper for the prefill reader
// Contents:
//   state_t        reader FSM states (IDLE / STREAM / DRAIN)
//   pop_cnt_width  bits needed to hold a pop count of 0..burst_len inclusive
package fifo_prefill_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // One extra bit so the counter can reach burst_len itself, not just burst_len-1.
  function automatic int pop_cnt_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/fifo_prefill_reader_skid.sv
// rtl/fifo_prefill_reader_skid.sv - 2-entry valid/ready output buffer carrying {last, data}
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   in_valid               word written this edge (caller guarantees occ < 2)
//   in_data, in_last       word and its end-of-burst tag
//   m_ready                downstream accept
//   m_valid, m_data,       registered head of the buffer; held stable while
//   m_last                 m_valid && !m_ready
//   occ                    occupancy, 0..2
module reader_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            occ
);

  // Second entry; only meaningful when occ == 2.
  logic [DATA_WIDTH-1:0] spare_data;
  logic                  spare_last;
  logic                  take;

  assign m_valid = (occ != 2'd0);
  assign take    = m_valid && m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ        <= 2'd0;
      m_data     <= '0;
      m_last     <= 1'b0;
      spare_data <= '0;
      spare_last <= 1'b0;
    end else begin
      case (occ)
        2'd0: begin
          if (in_valid) begin
            m_data <= in_data;
            m_last <= in_last;
            occ    <= 2'd1;
          end
        end
        2'd1: begin
          if (in_valid && take) begin
            // Head leaves and the new word replaces it: occupancy stays at 1.
            m_data <= in_data;
            m_last <= in_last;
          end else if (in_valid) begin
            spare_data <= in_data;
            spare_last <= in_last;
            occ        <= 2'd2;
          end else if (take) begin
            occ <= 2'd0;
          end
        end
        default: begin
          if (take) begin
            m_data <= spare_data;
            m_last <= spare_last;
            if (in_valid) begin
              spare_data <= in_data;
              spare_last <= in_last;
            end else begin
              occ <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_prefill_reader.sv
// rtl/fifo_prefill_reader.sv - prefill-gated burst reader from a FWFT FIFO onto a valid/ready stream
// Ports:
//   clk, rstn         FIFO read clock, asynchronous active-low reset
//   en                level enable, lets a new burst start (sampled only in IDLE)
//   prefill_done      synchronised FIFO prefill status (sampled only in IDLE)
//   fifo_empty        FIFO empty flag
//   fifo_rd_data      FIFO head word, valid while !fifo_empty
//   fifo_rd_en        pop strobe (combinational)
//   m_valid, m_ready  output stream handshake
//   m_data, m_last    output word and end-of-burst marker
//   burst_done        one-cycle pulse after the last word of a burst is accepted
//   busy              high whenever the FSM is not idle
//   underrun_cnt      saturating count of cycles starved by an empty FIFO
module fifo_prefill_reader
  import fifo_prefill_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int UNDERRUN_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  prefill_done,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  burst_done,
  output logic                  busy,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam int               CNT_W    = pop_cnt_width(BURST_LEN);
  localparam logic [CNT_W-1:0] LEN      = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pop_cnt;
  logic [1:0]       occ;
  logic             room;
  logic             accept_last;
  logic             starved;
  logic             done_nxt;

  assign room        = (occ != 2'd2);
  assign accept_last = m_valid && m_ready && m_last;
  // A cycle is starved only when we would have popped had the FIFO held data.
  assign starved     = (state == ST_STREAM) && fifo_empty && room && (pop_cnt < LEN);
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && prefill_done) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        fifo_rd_en = !fifo_empty && (pop_cnt < LEN) && room;
        if (fifo_rd_en && (pop_cnt == LAST_IDX)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last word was popped on the STREAM->DRAIN edge, so it can only
        // be accepted here; returning to IDLE guarantees an idle gap.
        if (accept_last) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pop_cnt      <= '0;
      burst_done   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      burst_done <= done_nxt;
      if ((state == ST_IDLE) && (state_nxt == ST_STREAM)) begin
        pop_cnt <= '0;
      end else if (fifo_rd_en) begin
        pop_cnt <= pop_cnt + CNT_W'(1);
      end
      if (starved && (underrun_cnt != {UNDERRUN_W{1'b1}})) begin
        underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);
      end
    end
  end

  reader_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .in_valid(fifo_rd_en),
    .in_data (fifo_rd_data),
    .in_last (pop_cnt == LAST_IDX),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .occ     (occ)
  );

endmodule

// File: tb/tb_fifo_prefill_reader.sv
// tb/tb_fifo_prefill_reader.sv - scoreboard bench for fifo_prefill_reader
module tb_fifo_prefill_reader;

  localparam int DW = 8;
  localparam int BL = 16;
  localparam int UW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic          prefill_done = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_ready = 1'b0;
  logic          fifo_rd_en, m_valid, m_last, burst_done, busy;
  logic [DW-1:0] m_data;
  logic [UW-1:0] underrun_cnt;

  // Second instance: permanently empty FIFO and a 2-bit counter, for saturation.
  logic          sat_pf = 1'b0;
  logic          sat_rd_en, sat_valid, sat_last, sat_done, sat_busy;
  logic [DW-1:0] sat_data;
  logic [1:0]    sat_cnt;

  always #5 clk = ~clk;

  fifo_prefill_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .UNDERRUN_W(UW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .prefill_done(prefill_done),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .burst_done(burst_done), .busy(busy), .underrun_cnt(underrun_cnt)
  );

  fifo_prefill_reader #(.DATA_WIDTH(DW), .BURST_LEN(2), .UNDERRUN_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .en(1'b1), .prefill_done(sat_pf),
    .fifo_empty(1'b1), .fifo_rd_data(8'h00), .fifo_rd_en(sat_rd_en),
    .m_valid(sat_valid), .m_ready(1'b1), .m_data(sat_data), .m_last(sat_last),
    .burst_done(sat_done), .busy(sat_busy), .underrun_cnt(sat_cnt)
  );

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW:0]   exp_q[$];
  int            n_acc = 0, n_done = 0, npops = 0, drop_at = 0, rmode = 0;
  int            cyc = 0, first_v = -1, last_acc = -1;
  logic          exp_done = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares accepted words against the scoreboard queue.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rstn) begin
      cyc++;
      if (burst_done || exp_done) begin
        check("burst_done", 32'(burst_done), 32'(exp_done));
        if (burst_done) begin
          n_done++;
          check("idle_gap_after_done", 32'(busy), 32'd0);
        end
      end
      exp_done = 1'b0;
      if (prev_stall) begin
        check("stall_valid_held", 32'(m_valid), 32'd1);
        check("stall_data_held", 32'(m_data), 32'(prev_data));
      end
      check("occ_le_2", 32'(dut.u_skid.occ != 2'd3), 32'd1);
      if (dut.u_skid.occ == 2'd2) check("no_pop_when_full", 32'(fifo_rd_en), 32'd0);
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h expected none", {m_last, m_data});
        end else begin
          e = exp_q.pop_front();
          check("stream_word", 32'({m_last, m_data}), 32'(e));
        end
        n_acc++;
        last_acc = cyc;
        if (m_last) exp_done = 1'b1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end else begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end
  end

  task automatic upd();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
  endtask

  // Loads words into the FIFO model; when expect_out, also into the scoreboard.
  task automatic load(input int base, input int n, input bit expect_out);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = DW'(base + i);
      fifo_q.push_back(d);
      if (expect_out) exp_q.push_back({d[3:0] == 4'hF, d});
    end
    upd();
  endtask

  // One clock: sample the pop strobe at the negedge, apply it after the posedge.
  task automatic step();
    logic do_pop;
    @(negedge clk);
    do_pop = fifo_rd_en;
    @(posedge clk);
    #1;
    if (do_pop && fifo_q.size() > 0) begin
      fifo_q.pop_front();
      npops++;
    end
    if (rmode == 1) m_ready = ~m_ready;
    if (en && busy && npops >= drop_at) en = 1'b0;
    upd();
  endtask

  task automatic wait_done(input string name);
    int d0;
    int k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < 300) begin
      step();
      k++;
    end
    if (n_done == d0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no burst_done expected one within 300 cycles", name);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
    check({tag, "_burst_done"}, 32'(burst_done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_underrun"}, 32'(underrun_cnt), 32'd0);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic seen_rd, seen_v, seen_busy;
    int   k;
    int   a0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rstn = 1'b1;
    m_ready = 1'b1;

    // Prefill gating, then a full-rate burst 0x00..0x0F.
    load(8'h00, 5, 1'b1);
    en = 1'b1;
    seen_rd = 0; seen_v = 0; seen_busy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen_rd |= fifo_rd_en; seen_v |= m_valid; seen_busy |= busy;
    end
    check("gate_rd_en", 32'(seen_rd), 32'd0);
    check("gate_m_valid", 32'(seen_v), 32'd0);
    check("gate_busy", 32'(seen_busy), 32'd0);
    load(8'h05, 11, 1'b1);
    first_v = -1;
    npops = 0;
    prefill_done = 1'b1;
    step();
    check("start_busy", 32'(busy), 32'd1);
    check("start_first_pop", 32'(fifo_rd_en), 32'd1);
    check("start_no_valid_yet", 32'(m_valid), 32'd0);
    step();
    check("first_word_valid", 32'(m_valid), 32'd1);
    check("first_word_data", 32'(m_data), 32'h00);
    wait_done("full_rate");
    check("full_rate_span", 32'(last_acc - first_v), 32'd15);
    check("full_rate_no_underrun", 32'(underrun_cnt), 32'd0);

    // Backpressure: m_ready toggles every cycle.
    load(8'h10, 16, 1'b1);
    npops = 0; drop_at = 0; rmode = 1; en = 1'b1;
    wait_done("backpressure");
    rmode = 0; m_ready = 1'b1;
    check("bp_no_underrun", 32'(underrun_cnt), 32'd0);

    // Underrun: FIFO empty for 4 cycles after 6 words.
    load(8'h20, 6, 1'b1);
    npops = 0; en = 1'b1;
    k = 0;
    while (npops < 6 && k < 50) begin step(); k++; end
    check("underrun_first_six", 32'(npops), 32'd6);
    repeat (4) step();
    load(8'h26, 10, 1'b1);
    wait_done("underrun");
    check("underrun_count", 32'(underrun_cnt), 32'd4);

    // Reset after 7 accepted words.
    load(8'h30, 16, 1'b1);
    npops = 0; en = 1'b1;
    a0 = n_acc; k = 0;
    while (n_acc - a0 < 7 && k < 50) begin step(); k++; end
    rstn = 1'b0;
    #1;
    check_reset_values("midreset");
    fifo_q.delete();
    exp_q.delete();
    upd();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    load(8'h40, 16, 1'b1);
    npops = 0; en = 1'b1;
    wait_done("after_reset");

    // en dropped at word 3: burst completes, then the block stays idle.
    load(8'h50, 16, 1'b1);
    npops = 0; drop_at = 3; en = 1'b1;
    wait_done("en_drop");
    drop_at = 0;
    load(8'h60, 4, 1'b0);
    seen_rd = 0; seen_busy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen_rd |= fifo_rd_en; seen_busy |= busy;
    end
    check("en_drop_idle_rd_en", 32'(seen_rd), 32'd0);
    check("en_drop_idle_busy", 32'(seen_busy), 32'd0);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    // Saturation on the 2-bit instance: reach max-1, then starve 3 more cycles.
    check("sat_initial", 32'(sat_cnt), 32'd0);
    sat_pf = 1'b1;
    repeat (3) step();
    check("sat_max_minus_1", 32'(sat_cnt), 32'd2);
    repeat (3) step();
    check("sat_holds_max", 32'(sat_cnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
